// File: rtl/id_ctrl_issue_if.sv
// ID/EX issue bundle: ID-side instruction fields and controls going in,
// registered EX control bundle plus pipeline hold/status coming out.
interface id_ctrl_issue_if #(
  parameter int CTRL_W = 18
) ();
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [4:0]        id_dest;
  logic              ex_hold;
  logic              branch_taken;
  logic [CTRL_W-1:0] control_signals;
  logic [4:0]        ex_dest;
  logic              ex_valid;
  logic              if_id_hold;
  logic              stall_active;

  // Pipeline side: supplies the ID instruction, observes the EX bundle.
  modport master (
    output id_valid, id_ctrl, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           ex_hold, branch_taken,
    input  control_signals, ex_dest, ex_valid, if_id_hold, stall_active
  );

  // Issue block side.
  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           ex_hold, branch_taken,
    output control_signals, ex_dest, ex_valid, if_id_hold, stall_active
  );
endinterface

// File: rtl/id_ctrl_issue.sv
// ID/EX issue stage: registers the decoded control word into EX, inserting
// load-use bubbles (LOAD_USE_STALL of them, 1..3), squashing on a taken
// branch and freezing everything while EX holds.
module id_ctrl_issue #(
  parameter int CTRL_W         = 18,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic            clk,
  input  logic            reset,
  id_ctrl_issue_if.slave  bus
);

  localparam int LOAD_BIT = 9;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e            state_r;
  state_e            state_n_s;
  logic [1:0]        cnt_r;
  logic [1:0]        cnt_n_s;
  logic [CTRL_W-1:0] ctrl_r;
  logic [CTRL_W-1:0] ctrl_n_s;
  logic [4:0]        dest_r;
  logic [4:0]        dest_n_s;
  logic              valid_r;
  logic              valid_n_s;
  logic              hold_s;
  logic              hz_s;

  // True when an enabled source field names the given destination register.
  function automatic logic src_match(input logic       uses_rs,
                                     input logic [4:0] rs,
                                     input logic       uses_rt,
                                     input logic [4:0] rt,
                                     input logic [4:0] dest);
    return (uses_rs & (rs == dest)) | (uses_rt & (rt == dest));
  endfunction

  // Load in EX writing a nonzero register that the ID instruction reads.
  assign hz_s = valid_r & ctrl_r[LOAD_BIT] & (dest_r != 5'd0) & bus.id_valid &
                src_match(bus.id_uses_rs, bus.id_rs, bus.id_uses_rt, bus.id_rt, dest_r);

  // Next-state and next-bundle selection in priority order: hold, branch, hazard, stall, issue.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    ctrl_n_s  = ctrl_r;
    dest_n_s  = dest_r;
    valid_n_s = valid_r;
    hold_s    = 1'b0;
    if (bus.ex_hold) begin
      hold_s = 1'b1;
    end else if (bus.branch_taken) begin
      ctrl_n_s  = {CTRL_W{1'b0}};
      dest_n_s  = 5'd0;
      valid_n_s = 1'b0;
      state_n_s = ST_RUN;
      cnt_n_s   = 2'd0;
    end else if ((state_r == ST_RUN) && hz_s) begin
      ctrl_n_s  = {CTRL_W{1'b0}};
      dest_n_s  = 5'd0;
      valid_n_s = 1'b0;
      cnt_n_s   = 2'(LOAD_USE_STALL - 1);
      state_n_s = (LOAD_USE_STALL > 1) ? ST_STALL : ST_RUN;
      hold_s    = 1'b1;
    end else if (state_r == ST_STALL) begin
      ctrl_n_s  = {CTRL_W{1'b0}};
      dest_n_s  = 5'd0;
      valid_n_s = 1'b0;
      cnt_n_s   = cnt_r - 2'd1;
      if (cnt_r <= 2'd1) begin
        state_n_s = ST_RUN;
      end else begin
        state_n_s = ST_STALL;
      end
      hold_s    = 1'b1;
    end else begin
      if (bus.id_valid) begin
        ctrl_n_s  = bus.id_ctrl;
        dest_n_s  = bus.id_dest;
        valid_n_s = 1'b1;
      end else begin
        ctrl_n_s  = {CTRL_W{1'b0}};
        dest_n_s  = 5'd0;
        valid_n_s = 1'b0;
      end
    end
  end

  // State, stall counter and EX bundle registers; reset leaves a bubble in EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      cnt_r   <= 2'd0;
      ctrl_r  <= {CTRL_W{1'b0}};
      dest_r  <= 5'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      ctrl_r  <= ctrl_n_s;
      dest_r  <= dest_n_s;
      valid_r <= valid_n_s;
    end
  end

  assign bus.control_signals = ctrl_r;
  assign bus.ex_dest         = dest_r;
  assign bus.ex_valid        = valid_r;
  assign bus.stall_active    = (state_r == ST_STALL);
  // Front-end freeze is released while reset is asserted.
  assign bus.if_id_hold      = reset & hold_s;

endmodule

// File: tb/tb_id_ctrl_issue.sv
// Bench for id_ctrl_issue: directed vector tables on a 1-bubble and a
// 3-bubble instance, then a randomized pipeline stream per instance checked
// against a bubble-counting reference model.
module tb_id_ctrl_issue;
  localparam int CTRL_W = 18;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ctrl_issue_if #(.CTRL_W(CTRL_W)) bus1 ();
  id_ctrl_issue_if #(.CTRL_W(CTRL_W)) bus3 ();

  id_ctrl_issue #(.CTRL_W(CTRL_W), .LOAD_USE_STALL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  id_ctrl_issue #(.CTRL_W(CTRL_W), .LOAD_USE_STALL(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct packed {
    logic        rst_n;
    logic        v;
    logic [17:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic [4:0]  dest;
    logic        hold;
    logic        br;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic        e_hold;
    logic [17:0] e_ctrl;
    logic [4:0]  e_dest;
    logic        e_valid;
    logic        e_stall;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst_n, input logic v, input logic [17:0] ctrl,
                              input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic [4:0] dest, input logic hold,
                              input logic br, input logic e_hold, input logic [17:0] e_ctrl,
                              input logic [4:0] e_dest, input logic e_valid, input logic e_stall);
    vec_t r;
    r.i       = '{rst_n, v, ctrl, rs, rt, urs, urt, dest, hold, br};
    r.e_hold  = e_hold;
    r.e_ctrl  = e_ctrl;
    r.e_dest  = e_dest;
    r.e_valid = e_valid;
    r.e_stall = e_stall;
    return r;
  endfunction

  task automatic drive(input int k, input in_t v);
    if (k == 0) begin
      bus1.id_valid = v.v;  bus1.id_ctrl = v.ctrl; bus1.id_rs = v.rs; bus1.id_rt = v.rt;
      bus1.id_uses_rs = v.urs; bus1.id_uses_rt = v.urt; bus1.id_dest = v.dest;
      bus1.ex_hold = v.hold; bus1.branch_taken = v.br;
    end else begin
      bus3.id_valid = v.v;  bus3.id_ctrl = v.ctrl; bus3.id_rs = v.rs; bus3.id_rt = v.rt;
      bus3.id_uses_rs = v.urs; bus3.id_uses_rt = v.urt; bus3.id_dest = v.dest;
      bus3.ex_hold = v.hold; bus3.branch_taken = v.br;
    end
  endtask

  function automatic logic [17:0] o_ctrl(input int k);
    return (k == 0) ? bus1.control_signals : bus3.control_signals;
  endfunction
  function automatic logic [4:0] o_dest(input int k);
    return (k == 0) ? bus1.ex_dest : bus3.ex_dest;
  endfunction
  function automatic logic o_valid(input int k);
    return (k == 0) ? bus1.ex_valid : bus3.ex_valid;
  endfunction
  function automatic logic o_stall(input int k);
    return (k == 0) ? bus1.stall_active : bus3.stall_active;
  endfunction
  function automatic logic o_hold(input int k);
    return (k == 0) ? bus1.if_id_hold : bus3.if_id_hold;
  endfunction

  // One directed cycle: same inputs to both instances, instance k checked.
  task automatic cycle(input int k, input string nm, input vec_t t);
    @(negedge clk);
    reset = t.i.rst_n;
    drive(0, t.i);
    drive(1, t.i);
    #1;
    chk({nm, "_hold"}, 32'(o_hold(k)), 32'(t.e_hold));
    @(posedge clk);
    #1;
    chk({nm, "_ctrl"},  32'(o_ctrl(k)),  32'(t.e_ctrl));
    chk({nm, "_dest"},  32'(o_dest(k)),  32'(t.e_dest));
    chk({nm, "_valid"}, 32'(o_valid(k)), 32'(t.e_valid));
    chk({nm, "_stall"}, 32'(o_stall(k)), 32'(t.e_stall));
  endtask

  // Reference model: EX bundle plus the number of bubbles still owed.
  logic [17:0] m_ctrl [2];
  logic [4:0]  m_dest [2];
  logic        m_valid[2];
  int          m_pend [2];
  int          lus    [2] = '{1, 3};

  function automatic logic m_hz(input int k, input in_t v);
    return m_valid[k] && m_ctrl[k][9] && (m_dest[k] != 5'd0) && v.v &&
           ((v.urs && (v.rs == m_dest[k])) || (v.urt && (v.rt == m_dest[k])));
  endfunction

  function automatic logic m_hold(input int k, input in_t v);
    return v.hold || (!v.br && ((m_pend[k] > 0) || m_hz(k, v)));
  endfunction

  // Advance model k by one edge; returns 1 when a real instruction issued.
  function automatic logic m_step(input int k, input in_t v);
    logic bub;
    logic hz;
    hz  = m_hz(k, v);
    bub = 1'b1;
    if (v.hold) return 1'b0;
    if (v.br) begin
      m_pend[k] = 0;
    end else if (m_pend[k] > 0) begin
      m_pend[k] = m_pend[k] - 1;
    end else if (hz) begin
      m_pend[k] = lus[k] - 1;
    end else if (v.v) begin
      bub = 1'b0;
    end
    m_ctrl[k]  = bub ? 18'h0 : v.ctrl;
    m_dest[k]  = bub ? 5'd0 : v.dest;
    m_valid[k] = !bub;
    return !bub;
  endfunction

  vec_t tbl1[17];
  vec_t tbl3[14];
  in_t  cur[2];
  logic adv[2];
  logic eh;
  int   issued;
  int   seq;

  initial begin
    // Instance with one bubble per load-use.
    tbl1[0]  = mk(0,1,18'h3FFFF,0,0,0,0,0, 0,0, 0,18'h00000,0,0,0);
    tbl1[1]  = mk(0,1,18'h3FFFF,0,0,0,0,0, 0,0, 0,18'h00000,0,0,0);
    tbl1[2]  = mk(0,1,18'h3FFFF,0,0,0,0,0, 0,0, 0,18'h00000,0,0,0);
    tbl1[3]  = mk(1,1,18'h3FFFF,0,0,0,0,0, 0,0, 0,18'h3FFFF,0,1,0);
    tbl1[4]  = mk(1,1,18'h00200,0,0,1,0,5, 0,0, 0,18'h00200,5,1,0);
    tbl1[5]  = mk(1,1,18'h04011,5,0,1,0,6, 0,0, 1,18'h00000,0,0,0);
    tbl1[6]  = mk(1,1,18'h04011,5,0,1,0,6, 0,0, 0,18'h04011,6,1,0);
    tbl1[7]  = mk(1,1,18'h00281,6,6,0,0,7, 0,0, 0,18'h00281,7,1,0);
    tbl1[8]  = mk(1,1,18'h12345,3,7,1,0,1, 0,0, 0,18'h12345,1,1,0);
    tbl1[9]  = mk(1,1,18'h1A2B3,0,0,0,0,2, 0,0, 0,18'h1A2B3,2,1,0);
    tbl1[10] = mk(1,1,18'h00001,2,0,1,0,3, 1,0, 1,18'h1A2B3,2,1,0);
    tbl1[11] = mk(1,1,18'h00002,2,0,1,0,3, 1,0, 1,18'h1A2B3,2,1,0);
    tbl1[12] = mk(1,1,18'h00003,2,0,1,0,3, 1,0, 1,18'h1A2B3,2,1,0);
    tbl1[13] = mk(1,1,18'h00004,2,0,1,0,3, 1,1, 1,18'h1A2B3,2,1,0);
    tbl1[14] = mk(1,1,18'h00005,2,0,1,0,3, 0,1, 0,18'h00000,0,0,0);
    tbl1[15] = mk(1,0,18'h3FFFF,0,0,0,0,9, 0,0, 0,18'h00000,0,0,0);
    tbl1[16] = mk(1,1,18'h0ABCD,0,0,0,0,3, 0,0, 0,18'h0ABCD,3,1,0);
    // Instance with three bubbles: full stall, branch abort, reset mid-stall.
    tbl3[0]  = mk(0,0,18'h00000,0,0,0,0,0, 0,0, 0,18'h00000,0,0,0);
    tbl3[1]  = mk(1,1,18'h00200,0,0,0,0,5, 0,0, 0,18'h00200,5,1,0);
    tbl3[2]  = mk(1,1,18'h04011,5,0,1,0,6, 0,0, 1,18'h00000,0,0,1);
    tbl3[3]  = mk(1,1,18'h04011,5,0,1,0,6, 0,0, 1,18'h00000,0,0,1);
    tbl3[4]  = mk(1,1,18'h04011,5,0,1,0,6, 0,0, 1,18'h00000,0,0,0);
    tbl3[5]  = mk(1,1,18'h04011,5,0,1,0,6, 0,0, 0,18'h04011,6,1,0);
    tbl3[6]  = mk(1,1,18'h00200,0,0,0,0,5, 0,0, 0,18'h00200,5,1,0);
    tbl3[7]  = mk(1,1,18'h04011,5,0,1,0,6, 0,0, 1,18'h00000,0,0,1);
    tbl3[8]  = mk(1,1,18'h04011,5,0,1,0,6, 0,1, 0,18'h00000,0,0,0);
    tbl3[9]  = mk(1,1,18'h00011,5,0,1,0,4, 0,0, 0,18'h00011,4,1,0);
    tbl3[10] = mk(1,1,18'h00200,0,0,0,0,5, 0,0, 0,18'h00200,5,1,0);
    tbl3[11] = mk(1,1,18'h04011,0,5,0,1,6, 0,0, 1,18'h00000,0,0,1);
    tbl3[12] = mk(0,1,18'h04011,0,5,0,1,6, 0,0, 0,18'h00000,0,0,0);
    tbl3[13] = mk(1,1,18'h04011,0,5,0,1,6, 0,0, 0,18'h04011,6,1,0);

    cur[0] = '0;
    drive(0, cur[0]);
    drive(1, cur[0]);
    for (int i = 0; i < 17; i++) cycle(0, $sformatf("t1_%0d", i), tbl1[i]);
    for (int i = 0; i < 14; i++) cycle(1, $sformatf("t3_%0d", i), tbl3[i]);

    // Randomized stream: ID advances only when the model says it is not frozen.
    @(negedge clk);
    reset = 1'b0;
    cur[0] = '0;
    cur[1] = '0;
    drive(0, cur[0]);
    drive(1, cur[1]);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_ctrl[k] = 18'h0; m_dest[k] = 5'd0; m_valid[k] = 1'b0; m_pend[k] = 0; adv[k] = 1'b1;
    end
    issued = 0;
    seq    = 0;
    for (int c = 0; c < 40000 && issued < 10000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (adv[k]) begin
          cur[k].rst_n = 1'b1;
          cur[k].v     = ($urandom_range(0, 7) != 0);
          cur[k].ctrl  = 18'($urandom);
          cur[k].ctrl[6:0] = 7'(seq);
          cur[k].rs    = 5'($urandom_range(0, 3));
          cur[k].rt    = 5'($urandom_range(0, 3));
          cur[k].urs   = 1'($urandom_range(0, 1));
          cur[k].urt   = 1'($urandom_range(0, 1));
          cur[k].dest  = 5'($urandom_range(0, 3));
          seq++;
        end
        cur[k].hold = ($urandom_range(0, 7) == 0);
        cur[k].br   = ($urandom_range(0, 9) == 0);
        drive(k, cur[k]);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        eh = m_hold(k, cur[k]);
        chk($sformatf("rnd%0d_hold", k), 32'(o_hold(k)), 32'(eh));
        adv[k] = !eh;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (m_step(k, cur[k]) && (k == 0)) issued++;
        chk($sformatf("rnd%0d_ctrl", k),  32'(o_ctrl(k)),  32'(m_ctrl[k]));
        chk($sformatf("rnd%0d_dest", k),  32'(o_dest(k)),  32'(m_dest[k]));
        chk($sformatf("rnd%0d_valid", k), 32'(o_valid(k)), 32'(m_valid[k]));
        chk($sformatf("rnd%0d_stall", k), 32'(o_stall(k)), 32'(m_pend[k] > 0));
      end
    end
    chk("rnd_issued_count", 32'(issued >= 10000), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
